// File: rtl/regfile_dual.sv
// rtl/regfile_dual.sv - dual-issue register file, two write lanes, four registered write-first read ports
module regfile_dual #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            hold_i,
    input  logic [AW-1:0]   rs1_addr0_i,
    input  logic [AW-1:0]   rs2_addr0_i,
    input  logic [AW-1:0]   rs1_addr1_i,
    input  logic [AW-1:0]   rs2_addr1_i,
    input  logic            rd_we0_i,
    input  logic [AW-1:0]   rd_addr0_i,
    input  logic [XLEN-1:0] rd_data0_i,
    input  logic            rd_we1_i,
    input  logic [AW-1:0]   rd_addr1_i,
    input  logic [XLEN-1:0] rd_data1_i,
    output logic [XLEN-1:0] rs1_data0_o,
    output logic [XLEN-1:0] rs2_data0_o,
    output logic [XLEN-1:0] rs1_data1_o,
    output logic [XLEN-1:0] rs2_data1_o
);

    localparam int NPORTS = 4;

    logic [XLEN-1:0] mem_q  [NREGS];
    logic [XLEN-1:0] mem_d  [NREGS];
    logic [AW-1:0]   addr_q [NPORTS];
    logic [AW-1:0]   addr_d [NPORTS];
    logic [XLEN-1:0] out_q  [NPORTS];
    logic [XLEN-1:0] out_d  [NPORTS];
    logic [AW-1:0]   raddr  [NPORTS];

    logic wr0_en;
    logic wr1_en;

    assign raddr[0] = rs1_addr0_i;
    assign raddr[1] = rs2_addr0_i;
    assign raddr[2] = rs1_addr1_i;
    assign raddr[3] = rs2_addr1_i;

    // Writes to x0 are squashed here so every hit test below can ignore x0.
    assign wr0_en = rd_we0_i && (rd_addr0_i != '0);
    assign wr1_en = rd_we1_i && (rd_addr1_i != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr0_en) begin
            mem_d[rd_addr0_i] = rd_data0_i;
        end
        if (wr1_en) begin
            mem_d[rd_addr1_i] = rd_data1_i;
        end
        mem_d[0] = '0;
    end

    // Lane 1 is younger, so its write takes priority on any bypass match.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            addr_d[p] = hold_i ? addr_q[p] : raddr[p];
            if (wr1_en && (rd_addr1_i == addr_d[p])) begin
                out_d[p] = rd_data1_i;
            end else if (wr0_en && (rd_addr0_i == addr_d[p])) begin
                out_d[p] = rd_data0_i;
            end else if (hold_i) begin
                out_d[p] = out_q[p];
            end else begin
                out_d[p] = mem_q[addr_d[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            for (int p = 0; p < NPORTS; p++) begin
                addr_q[p] <= '0;
                out_q[p]  <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            addr_q <= addr_d;
            out_q  <= out_d;
        end
    end

    assign rs1_data0_o = out_q[0];
    assign rs2_data0_o = out_q[1];
    assign rs1_data1_o = out_q[2];
    assign rs2_data1_o = out_q[3];

endmodule

// File: tb/tb_regfile_dual.sv
// tb/tb_regfile_dual.sv - table-driven and randomized scoreboard bench for regfile_dual
module tb_regfile_dual;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        hold_i;
    logic [4:0]  rs1_addr0_i, rs2_addr0_i, rs1_addr1_i, rs2_addr1_i;
    logic        rd_we0_i, rd_we1_i;
    logic [4:0]  rd_addr0_i, rd_addr1_i;
    logic [31:0] rd_data0_i, rd_data1_i;
    logic [31:0] rs1_data0_o, rs2_data0_o, rs1_data1_o, rs2_data1_o;

    always #5 clk = ~clk;

    regfile_dual dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .hold_i      (hold_i),
        .rs1_addr0_i (rs1_addr0_i),
        .rs2_addr0_i (rs2_addr0_i),
        .rs1_addr1_i (rs1_addr1_i),
        .rs2_addr1_i (rs2_addr1_i),
        .rd_we0_i    (rd_we0_i),
        .rd_addr0_i  (rd_addr0_i),
        .rd_data0_i  (rd_data0_i),
        .rd_we1_i    (rd_we1_i),
        .rd_addr1_i  (rd_addr1_i),
        .rd_data1_i  (rd_data1_i),
        .rs1_data0_o (rs1_data0_o),
        .rs2_data0_o (rs2_data0_o),
        .rs1_data1_o (rs1_data1_o),
        .rs2_data1_o (rs2_data1_o)
    );

    typedef struct packed {
        logic             rstn;
        logic             hold;
        logic [3:0][4:0]  ra;
        logic             we0;
        logic [4:0]       a0;
        logic [31:0]      d0;
        logic             we1;
        logic [4:0]       a1;
        logic [31:0]      d1;
        logic [3:0][31:0] exp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    logic [3:0][31:0] sb_q [$];
    logic [31:0]      ref_mem [32];
    logic [3:0][4:0]  ref_lat;
    logic [3:0][31:0] model_exp;
    int tests  = 0;
    int errors = 0;

    function automatic vec_t mk(input logic rstn, input logic hold,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] r3,
                                input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.rstn = rstn; v.hold = hold;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Reference: apply the writes in age order, then every port shows the current
    // architectural value of whatever address it has latched.
    task automatic drive(input vec_t v, input logic use_model);
        rst_ni = v.rstn; hold_i = v.hold;
        rs1_addr0_i = v.ra[0]; rs2_addr0_i = v.ra[1];
        rs1_addr1_i = v.ra[2]; rs2_addr1_i = v.ra[3];
        rd_we0_i = v.we0; rd_addr0_i = v.a0; rd_data0_i = v.d0;
        rd_we1_i = v.we1; rd_addr1_i = v.a1; rd_data1_i = v.d1;
        if (!v.rstn) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
            ref_lat = '0;
        end else begin
            if (v.we0) ref_mem[v.a0] = v.d0;
            if (v.we1) ref_mem[v.a1] = v.d1;
            ref_mem[0] = 32'h0;
            if (!v.hold) ref_lat = v.ra;
        end
        for (int p = 0; p < 4; p++) model_exp[p] = ref_mem[ref_lat[p]];
        sb_q.push_back(use_model ? model_exp : v.exp);
    endtask

    task automatic check(input string tag, input int idx);
        logic [3:0][31:0] exp;
        logic [3:0][31:0] act;
        act[0] = rs1_data0_o; act[1] = rs2_data0_o;
        act[2] = rs1_data1_o; act[3] = rs2_data1_o;
        if (sb_q.size() == 0) begin
            tests++; errors++;
            $display("FAIL %s%0d scoreboard empty", tag, idx);
            return;
        end
        exp = sb_q.pop_front();
        for (int p = 0; p < 4; p++) begin
            tests++;
            if (act[p] !== exp[p]) begin
                errors++;
                $display("FAIL %s%0d port%0d got %h expected %h", tag, idx, p, act[p], exp[p]);
            end
        end
    endtask

    initial begin
        // reset with hold and a pending write: reset must win
        tbl[0]  = mk(0,1, 1,2,3,4, 1,12,32'h1111_1111, 1,13,32'h2222_2222, 0,0,0,0);
        tbl[1]  = mk(1,0, 1,2,3,4, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[2]  = mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[3]  = mk(1,0, 5,0,0,0, 1,5,32'hDEAD_BEEF, 0,0,0, 32'hDEAD_BEEF,0,0,0);
        tbl[4]  = mk(1,0, 5,0,0,7, 1,7,32'h11, 1,7,32'h22, 32'hDEAD_BEEF,0,0,32'h22);
        tbl[5]  = mk(1,0, 0,7,0,7, 0,0,0, 0,0,0, 0,32'h22,0,32'h22);
        tbl[6]  = mk(1,0, 0,0,0,0, 1,0,32'hFFFF_FFFF, 1,0,32'hFFFF_FFFF, 0,0,0,0);
        tbl[7]  = mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[8]  = mk(1,0, 9,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[9]  = mk(1,1, 3,0,0,0, 0,0,0, 1,9,32'hA5A5_A5A5, 32'hA5A5_A5A5,0,0,0);
        tbl[10] = mk(1,1, 3,0,0,0, 1,3,32'h33, 0,0,0, 32'hA5A5_A5A5,0,0,0);
        tbl[11] = mk(1,0, 3,0,0,0, 0,0,0, 0,0,0, 32'h33,0,0,0);
        tbl[12] = mk(1,0, 0,12,0,0, 1,12,32'h1234, 0,0,0, 0,32'h1234,0,0);
        tbl[13] = mk(0,1, 0,12,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[14] = mk(1,0, 0,12,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[15] = mk(1,0, 0,0,20,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[16] = mk(1,1, 1,1,1,1, 1,20,32'hAA, 1,21,32'hBB, 0,0,32'hAA,0);
        tbl[17] = mk(1,1, 1,1,1,1, 1,20,32'h1, 1,20,32'h2, 0,0,32'h2,0);
        tbl[18] = mk(1,0, 7,7,7,7, 1,7,32'h77, 0,0,0, 32'h77,32'h77,32'h77,32'h77);

        rst_ni = 1'b0; hold_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_lat = '0;

        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            drive(tbl[v], 1'b0);
            @(posedge clk);
            #1;
            check("vec", v);
        end

        for (int n = 0; n < 400; n++) begin
            vec_t r;
            r.rstn = ($urandom_range(0, 99) != 0);
            r.hold = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < 4; p++) r.ra[p] = 5'($urandom_range(0, 7));
            r.we0 = $urandom_range(0, 1) == 1; r.a0 = 5'($urandom_range(0, 7)); r.d0 = $urandom;
            r.we1 = $urandom_range(0, 1) == 1; r.a1 = 5'($urandom_range(0, 7)); r.d1 = $urandom;
            r.exp = '0;
            @(negedge clk);
            drive(r, 1'b1);
            @(posedge clk);
            #1;
            check("rnd", n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
